affine_sbmv_gen: RTL

//  Upstream feeder of calc_addr in the affine MC path. Takes one CU's control-point MVs (4/6-param),

---
 rtl/affine_pkg.sv | 44 ++++
 rtl/affine_mv_round.sv | 44 ++++
 rtl/affine_sbmv_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/affine_pkg.sv
// Shared types and constants for the affine subblock MV generator.
package affine_pkg;

    localparam int MV_W     = 18;
    localparam int ACC_W    = 32;
    localparam int INT_W    = 13;
    localparam int FRAC_W   = 5;
    localparam int MV_OUT_W = INT_W + 4;
    localparam int CNT_W    = 5;
    localparam int CLIP_MIN = -65536;
    localparam int CLIP_MAX = 65535;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELTA = 3'd1,
        ST_INIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0]        dif_x;
        logic [7:0]        dif_y;
        logic [INT_W-1:0]  int_x;
        logic [INT_W-1:0]  int_y;
        logic [FRAC_W-1:0] frac_x;
        logic [FRAC_W-1:0] frac_y;
        logic              last;
    } sb_out_t;

    // (a - b) scaled into the 2^7 accumulator domain for one CU dimension
    function automatic logic signed [ACC_W-1:0] scale_diff(
        input logic signed [MV_W-1:0] a,
        input logic signed [MV_W-1:0] b,
        input logic [2:0]             sh
    );
        logic signed [ACC_W-1:0] ea;
        logic signed [ACC_W-1:0] eb;
        ea = ACC_W'(a);
        eb = ACC_W'(b);
        return (ea - eb) <<< sh;
    endfunction

endpackage

// File: rtl/affine_mv_round.sv
// Round-half-away-from-zero of a 2^7-scaled accumulator, clip, and split into integer/fraction.
module affine_mv_round
    import affine_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc,
    output logic [INT_W-1:0]        mv_int,
    output logic [FRAC_W-1:0]       mv_frac
);

    localparam logic signed [ACC_W:0] CMAX = (ACC_W+1)'(CLIP_MAX);
    localparam logic signed [ACC_W:0] CMIN = (ACC_W+1)'(CLIP_MIN);

    logic signed [ACC_W:0]   acc_ext_s;
    logic signed [ACC_W:0]   mag_s;
    logic signed [ACC_W:0]   rnd_s;
    logic signed [ACC_W:0]   mv_full_s;
    logic [MV_OUT_W-1:0]     mv_clip_s;

    // magnitude rounding keeps the result symmetric around zero
    always_comb begin
        acc_ext_s = {acc[ACC_W-1], acc};
        if (acc_ext_s[ACC_W]) begin
            mag_s = -acc_ext_s;
        end else begin
            mag_s = acc_ext_s;
        end
        rnd_s = (mag_s + (ACC_W+1)'(64)) >>> 3'd7;
        if (acc_ext_s[ACC_W]) begin
            mv_full_s = -rnd_s;
        end else begin
            mv_full_s = rnd_s;
        end
        if (mv_full_s > CMAX) begin
            mv_clip_s = MV_OUT_W'(CLIP_MAX);
        end else if (mv_full_s < CMIN) begin
            mv_clip_s = MV_OUT_W'(CLIP_MIN);
        end else begin
            mv_clip_s = mv_full_s[MV_OUT_W-1:0];
        end
        mv_int  = mv_clip_s[MV_OUT_W-1:4];
        mv_frac = {{(FRAC_W-4){1'b0}}, mv_clip_s[3:0]};
    end

endmodule

// File: rtl/affine_sbmv_gen.sv
// Walks one affine CU's 4x4 subblocks in raster order, emitting one rounded MV per handshake.
module affine_sbmv_gen
    import affine_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [11:0]              cu_x,
    input  logic [11:0]              cu_y,
    input  logic [2:0]               cu_log2w,
    input  logic [2:0]               cu_log2h,
    input  logic                     six_para,
    input  logic signed [MV_W-1:0]   cpmv0_x,
    input  logic signed [MV_W-1:0]   cpmv0_y,
    input  logic signed [MV_W-1:0]   cpmv1_x,
    input  logic signed [MV_W-1:0]   cpmv1_y,
    input  logic signed [MV_W-1:0]   cpmv2_x,
    input  logic signed [MV_W-1:0]   cpmv2_y,
    output logic                     busy,
    output logic                     sb_valid,
    input  logic                     sb_ready,
    output logic [11:0]              Ipu_x,
    output logic [11:0]              Ipu_y,
    output logic signed [7:0]        blk4x4_dif_coor_x,
    output logic signed [7:0]        blk4x4_dif_coor_y,
    output logic signed [INT_W-1:0]  vect_4para_Int_x,
    output logic signed [INT_W-1:0]  vect_4para_Int_y,
    output logic [FRAC_W-1:0]        vect_4para_Frac_x,
    output logic [FRAC_W-1:0]        vect_4para_Frac_y,
    output logic                     sb_last,
    output logic                     done
);

    state_t state_r, next_state_s;

    logic [2:0]              log2w_r, log2h_r;
    logic                    six_r;
    logic signed [MV_W-1:0]  mv0x_r, mv0y_r, mv1x_r, mv1y_r, mv2x_r, mv2y_r;
    logic signed [ACC_W-1:0] d_hor_x_r, d_hor_y_r, d_ver_x_r, d_ver_y_r;
    logic signed [ACC_W-1:0] d_hor_x_s, d_hor_y_s, d_ver_x_s, d_ver_y_s;
    logic signed [ACC_W-1:0] acc_x_r, acc_y_r, row_x_r, row_y_r;
    logic signed [ACC_W-1:0] base_x_s, base_y_s, next_row_x_s, next_row_y_s;
    logic [CNT_W-1:0]        sb_x_r, sb_y_r, cols_m1_s, rows_m1_s;
    logic                    load_s, row_end_s, last_s;
    logic [INT_W-1:0]        int_x_s, int_y_s;
    logic [FRAC_W-1:0]       frac_x_s, frac_y_s;
    sb_out_t                 out_r;
    logic                    sb_valid_r, busy_r, done_r;
    logic [11:0]             ipu_x_r, ipu_y_r;

    assign load_s    = (state_r == ST_RUN) && (!sb_valid_r || sb_ready);
    assign cols_m1_s = CNT_W'((8'd1 << (log2w_r - 3'd2)) - 8'd1);
    assign rows_m1_s = CNT_W'((8'd1 << (log2h_r - 3'd2)) - 8'd1);
    assign row_end_s = (sb_x_r == cols_m1_s);
    assign last_s    = row_end_s && (sb_y_r == rows_m1_s);

    // per-step deltas; the 4-param model derives the vertical gradient by rotation
    always_comb begin
        d_hor_x_s = scale_diff(mv1x_r, mv0x_r, 3'd7 - log2w_r);
        d_hor_y_s = scale_diff(mv1y_r, mv0y_r, 3'd7 - log2w_r);
        if (six_r) begin
            d_ver_x_s = scale_diff(mv2x_r, mv0x_r, 3'd7 - log2h_r);
            d_ver_y_s = scale_diff(mv2y_r, mv0y_r, 3'd7 - log2h_r);
        end else begin
            d_ver_x_s = -d_hor_y_s;
            d_ver_y_s = d_hor_x_s;
        end
    end

    assign base_x_s     = (ACC_W'(mv0x_r) <<< 3'd7) + (d_hor_x_r <<< 3'd1) + (d_ver_x_r <<< 3'd1);
    assign base_y_s     = (ACC_W'(mv0y_r) <<< 3'd7) + (d_hor_y_r <<< 3'd1) + (d_ver_y_r <<< 3'd1);
    assign next_row_x_s = row_x_r + (d_ver_x_r <<< 3'd2);
    assign next_row_y_s = row_y_r + (d_ver_y_r <<< 3'd2);

    affine_mv_round u_round_x (.acc(acc_x_r), .mv_int(int_x_s), .mv_frac(frac_x_s));
    affine_mv_round u_round_y (.acc(acc_y_r), .mv_int(int_y_s), .mv_frac(frac_y_s));

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_DELTA;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DELTA: next_state_s = ST_INIT;
            ST_INIT:  next_state_s = ST_RUN;
            ST_RUN: begin
                if (load_s && last_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (sb_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // command latch, gradient setup, accumulator walk and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            log2w_r <= 3'd0;  log2h_r <= 3'd0;  six_r <= 1'b0;
            mv0x_r <= '0; mv0y_r <= '0; mv1x_r <= '0; mv1y_r <= '0; mv2x_r <= '0; mv2y_r <= '0;
            d_hor_x_r <= '0; d_hor_y_r <= '0; d_ver_x_r <= '0; d_ver_y_r <= '0;
            acc_x_r <= '0; acc_y_r <= '0; row_x_r <= '0; row_y_r <= '0;
            sb_x_r <= '0; sb_y_r <= '0;
            out_r <= '0;
            sb_valid_r <= 1'b0; busy_r <= 1'b0; done_r <= 1'b0;
            ipu_x_r <= 12'd0; ipu_y_r <= 12'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy_r  <= 1'b1;
                        ipu_x_r <= cu_x;     ipu_y_r <= cu_y;
                        log2w_r <= cu_log2w; log2h_r <= cu_log2h;
                        six_r   <= six_para;
                        mv0x_r <= cpmv0_x; mv0y_r <= cpmv0_y;
                        mv1x_r <= cpmv1_x; mv1y_r <= cpmv1_y;
                        mv2x_r <= cpmv2_x; mv2y_r <= cpmv2_y;
                    end
                end
                ST_DELTA: begin
                    d_hor_x_r <= d_hor_x_s; d_hor_y_r <= d_hor_y_s;
                    d_ver_x_r <= d_ver_x_s; d_ver_y_r <= d_ver_y_s;
                end
                ST_INIT: begin
                    acc_x_r <= base_x_s; row_x_r <= base_x_s;
                    acc_y_r <= base_y_s; row_y_r <= base_y_s;
                    sb_x_r  <= '0;       sb_y_r  <= '0;
                end
                ST_RUN: begin
                    if (load_s) begin
                        sb_valid_r   <= 1'b1;
                        out_r.dif_x  <= {1'b0, sb_x_r, 2'b00};
                        out_r.dif_y  <= {1'b0, sb_y_r, 2'b00};
                        out_r.int_x  <= int_x_s;
                        out_r.int_y  <= int_y_s;
                        out_r.frac_x <= frac_x_s;
                        out_r.frac_y <= frac_y_s;
                        out_r.last   <= last_s;
                        if (row_end_s) begin
                            sb_x_r  <= '0;
                            sb_y_r  <= sb_y_r + 5'd1;
                            row_x_r <= next_row_x_s; acc_x_r <= next_row_x_s;
                            row_y_r <= next_row_y_s; acc_y_r <= next_row_y_s;
                        end else begin
                            sb_x_r  <= sb_x_r + 5'd1;
                            acc_x_r <= acc_x_r + (d_hor_x_r <<< 3'd2);
                            acc_y_r <= acc_y_r + (d_hor_y_r <<< 3'd2);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (sb_ready) begin
                        sb_valid_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy              = busy_r;
    assign sb_valid          = sb_valid_r;
    assign done              = done_r;
    assign Ipu_x             = ipu_x_r;
    assign Ipu_y             = ipu_y_r;
    assign blk4x4_dif_coor_x = out_r.dif_x;
    assign blk4x4_dif_coor_y = out_r.dif_y;
    assign vect_4para_Int_x  = out_r.int_x;
    assign vect_4para_Int_y  = out_r.int_y;
    assign vect_4para_Frac_x = out_r.frac_x;
    assign vect_4para_Frac_y = out_r.frac_y;
    assign sb_last           = out_r.last;

endmodule
